// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl: PDM mic clock divider, ones-count decimator, buffer writer.
// Define MIC_CTRL_LOOP_EN for circular recording with a done pulse per wrap.
module mic_capture_ctrl #(
   parameter int CLK_DIV  = 2,
   parameter int WIN_BITS = 2,
   parameter int WARM_WIN = 1,
   parameter int ADDR_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              dataint,
   output logic              mclk,
   output logic              mic_en,
   output logic [WIN_BITS:0] sample,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              busy,
   output logic              done
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WW = (WARM_WIN > 0) ? $clog2(WARM_WIN + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WARMUP,
      CAPTURE,
      DONE
   } state_t;

   state_t              state, state_n;
   logic [DW-1:0]       div_cnt;
   logic [WIN_BITS-1:0] bit_cnt;
   logic [WIN_BITS:0]   acc;
   logic [WW-1:0]       warm_cnt;
   logic                run, strobe, win_end, last_wr, go, abort;

   assign run     = (state == WARMUP) || (state == CAPTURE);
   assign strobe  = run && (div_cnt == DW'(CLK_DIV - 1)) && !mclk;
   assign win_end = strobe && (bit_cnt == '1);
   assign last_wr = mem_we && (mem_addr == '1);
   assign go      = start && !stop && !run;
   assign abort   = run && stop;
   assign busy    = run;
   assign mic_en  = run;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state decode
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, DONE: begin
            if (go) state_n = (WARM_WIN == 0) ? CAPTURE : WARMUP;
         end
         WARMUP: begin
            if (stop) state_n = IDLE;
            else if (win_end && (int'(warm_cnt) == WARM_WIN - 1))
               state_n = CAPTURE;
         end
         CAPTURE: begin
            if (stop) state_n = IDLE;
`ifndef MIC_CTRL_LOOP_EN
            else if (last_wr) state_n = DONE;
`endif
         end
      endcase
   end

   // Divider, decimator and buffer write sequencing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt  <= '0;
         bit_cnt  <= '0;
         acc      <= '0;
         warm_cnt <= '0;
         mclk     <= 1'b0;
         sample   <= '0;
         mem_addr <= '0;
         mem_we   <= 1'b0;
         done     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
`ifdef MIC_CTRL_LOOP_EN
         done <= 1'b0;
`endif
         if (go) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            acc      <= '0;
            warm_cnt <= '0;
            mclk     <= 1'b0;
            mem_addr <= '0;
            done     <= 1'b0;
         end else if (abort) begin
            mclk <= 1'b0;
         end else if (run) begin
            if (div_cnt == DW'(CLK_DIV - 1)) begin
               div_cnt <= '0;
               mclk    <= ~mclk;
            end else begin
               div_cnt <= div_cnt + DW'(1);
            end
            if (strobe) begin
               bit_cnt <= bit_cnt + WIN_BITS'(1);
               if (win_end) begin
                  acc <= '0;
                  if (state == WARMUP) begin
                     warm_cnt <= warm_cnt + WW'(1);
                  end else begin
                     sample <= acc + {{WIN_BITS{1'b0}}, dataint};
                     mem_we <= 1'b1;
                  end
               end else begin
                  acc <= acc + {{WIN_BITS{1'b0}}, dataint};
               end
            end
            if (mem_we) begin
               mem_addr <= mem_addr + ADDR_W'(1);
               if (last_wr) begin
                  done <= 1'b1;
`ifndef MIC_CTRL_LOOP_EN
                  mclk <= 1'b0;
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// tb_mic_capture_ctrl: directed + random checks of mic_capture_ctrl
// against an edge-timeline model built from window arithmetic.
module tb_mic_capture_ctrl;

   localparam int CLK_DIV  = 2;
   localparam int WIN_BITS = 2;
   localparam int WARM_WIN = 1;
   localparam int ADDR_W   = 2;
   localparam int N = 1 << WIN_BITS;
   localparam int P = 2 * CLK_DIV;
   localparam int D = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              dataint = 1'b0;
   logic              mclk, mic_en, mem_we, busy, done;
   logic [WIN_BITS:0] sample;
   logic [ADDR_W-1:0] mem_addr;

   mic_capture_ctrl #(
      .CLK_DIV(CLK_DIV), .WIN_BITS(WIN_BITS),
      .WARM_WIN(WARM_WIN), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .dataint(dataint), .mclk(mclk), .mic_en(mic_en),
      .sample(sample), .mem_addr(mem_addr), .mem_we(mem_we),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int nassert = 0;
   int nfail = 0;
   int e = 0;
   int s = 0;
   int k = 0;
   int dm = 0;
   bit active = 1'b0;
   bit st_q, sp_q, rs_q;
   logic [31:0] x_addr = 0, x_samp = 0, x_done = 0, x_we = 0;
   logic bits [0:4095];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s at edge %0d: observed %0h expected %0h",
                tag, e, obs, exp);
      end
   endtask

   function automatic int wedge(input int kk);
      return s + CLK_DIV + ((WARM_WIN + 1 + kk) * N - 1) * P;
   endfunction

   function automatic int wsum(input int kk);
      int sum = 0;
      for (int j = (WARM_WIN + kk) * N; j < (WARM_WIN + kk + 1) * N; j++)
         sum += (bits[s + CLK_DIV + j * P] === 1'b1) ? 1 : 0;
      return sum;
   endfunction

   task automatic model_reset();
      active = 1'b0;
      x_addr = 0;
      x_samp = 0;
      x_done = 0;
      x_we   = 0;
   endtask

   task automatic model_step();
      x_we = 0;
`ifdef MIC_CTRL_LOOP_EN
      x_done = 0;
`endif
      if (!rs_q) begin
         model_reset();
      end else if (st_q && !sp_q && !active) begin
         s = e; active = 1'b1; k = 0; x_addr = 0; x_done = 0;
      end else if (sp_q && active) begin
         active = 1'b0;
      end else if (active) begin
         if (k > 0 && e == wedge(k - 1) + 1) begin
            x_addr = (x_addr + 1) % D;
            if ((k - 1) % D == D - 1) begin
               x_done = 1;
`ifndef MIC_CTRL_LOOP_EN
               active = 1'b0;
`endif
            end
         end
         if (e == wedge(k)) begin
            x_we = 1; x_samp = wsum(k); k++;
         end
      end
   endtask

   task automatic check_all();
      chk("mclk", mclk, active ? ((e - s) / CLK_DIV) % 2 : 0);
      chk("busy", busy, active);
      chk("mic_en", mic_en, active);
      chk("done", done, x_done);
      chk("mem_we", mem_we, x_we);
      chk("mem_addr", mem_addr, x_addr);
      chk("sample", sample, x_samp);
   endtask

   task automatic next_data();
      int t1;
      t1 = e + 1 - s;
      case (dm)
         1: dataint = 1'b1;
         2: dataint = 1'b0;
         3: begin
            if (active && t1 >= CLK_DIV && (t1 - CLK_DIV) % P == 0)
               dataint = (((t1 - CLK_DIV) / P) % 4) != 1;
            else
               dataint = 1'($urandom % 2);
         end
         default: dataint = 1'($urandom % 2);
      endcase
   endtask

   task automatic cyc();
      bits[e + 1] = dataint;
      st_q = start; sp_q = stop; rs_q = reset;
      @(posedge clk);
      e++;
      #1;
      model_step();
      check_all();
      start = 1'b0;
      stop  = 1'b0;
      next_data();
   endtask

   task automatic adv(input int t);
      while (e - s < t) cyc();
   endtask

   task automatic kick(input int mode, input logic d0);
      dm = mode;
      dataint = d0;
      start = 1'b1;
      cyc();
   endtask

   initial begin
      // reset held low, then idle for 200 cycles
      repeat (3) cyc();
      reset = 1'b1;
      dm = 0;
      repeat (200) cyc();
      chk("idle_mclk", mclk, 0);

      // constant ones
      kick(1, 1'b1);
      adv(30);
      chk("ones_we30", mem_we, 1);
      chk("ones_s30", sample, 4);
      chk("ones_a30", mem_addr, 0);
      adv(31);
      chk("ones_we31", mem_we, 0);
      adv(78);
      chk("ones_a78", mem_addr, 3);
      adv(79);
      chk("ones_done79", done, 1);
`ifndef MIC_CTRL_LOOP_EN
      chk("ones_busy79", busy, 0);
      chk("ones_mclk79", mclk, 0);
`else
      chk("ones_busy79", busy, 1);
`endif
      adv(90);
      stop = 1'b1;
      cyc();

      // 1,0,1,1 pattern
      kick(3, 1'b0);
      adv(30);
      chk("pat_s30", sample, 3);
      adv(90);
      stop = 1'b1;
      cyc();

      // all zeros
      kick(2, 1'b0);
      adv(30);
      chk("zero_s30", sample, 0);
      adv(85);
      stop = 1'b1;
      cyc();

      // random data, full run
      kick(0, 1'b1);
      adv(100);
      stop = 1'b1;
      cyc();

      // abort after first write, then restart
      kick(0, 1'b0);
      adv(40);
      stop = 1'b1;
      cyc();
      chk("abort_busy", busy, 0);
      chk("abort_mclk", mclk, 0);
      chk("abort_addr", mem_addr, 1);
      repeat (30) cyc();
      kick(0, 1'b1);
      adv(30);
      chk("restart_we", mem_we, 1);
      chk("restart_a", mem_addr, 0);
      adv(40);

      // start while busy is ignored
      start = 1'b1;
      cyc();
      chk("ign_start_a", mem_addr, 1);
      adv(50);

      // async reset mid-capture
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_busy", busy, 0);
      chk("rst_addr", mem_addr, 0);
      repeat (2) cyc();
      reset = 1'b1;
      repeat (60) cyc();

`ifdef MIC_CTRL_LOOP_EN
      // circular recording, six windows
      kick(1, 1'b1);
      adv(wedge(4) - s);
      chk("loop_we4", mem_we, 1);
      chk("loop_a4", mem_addr, 0);
      adv(wedge(5) - s + 2);
      chk("loop_a6", mem_addr, 2);
      chk("loop_busy", busy, 1);
      stop = 1'b1;
      cyc();
      chk("loop_stop", busy, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               nassert, nfail);
      $finish;
   end

endmodule
